otp_pad_bank: RTL and testbench

OTP_PAD_BANK -- requirements
Module: otp_pad_bank

---
 rtl/otp_pad_bank.sv | 77 +++++++
 tb/tb_otp_pad_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/otp_pad_bank.sv
// otp_pad_bank: LFSR one-time-pad generator feeding an 8-slot FIFO bank with indexed decrypt reads
module otp_pad_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_load,
  input  logic [7:0] seed,
  input  logic       gen_en,
  output logic       pad_valid,
  input  logic       pad_ready,
  output logic [7:0] pad,
  output logic [2:0] pad_idx,
  input  logic       rd_req,
  input  logic [2:0] rd_idx,
  output logic       rd_ack,
  output logic [7:0] rd_pad,
  output logic       rd_hit,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic [7:0] written_q, written_d;
  logic [7:0] mem_q [8];
  logic       rd_ack_q, rd_hit_q;
  logic [7:0] rd_pad_q;
  logic       gen, cons;
  assign full      = count_q == 4'd8;
  assign empty     = count_q == 4'd0;
  assign count     = count_q;
  assign pad_valid = ~empty;
  assign pad       = mem_q[rd_ptr_q];
  assign pad_idx   = rd_ptr_q;
  assign rd_ack    = rd_ack_q;
  assign rd_pad    = rd_pad_q;
  assign rd_hit    = rd_hit_q;
  assign gen       = gen_en & ~full & ~seed_load;
  assign cons      = pad_ready & ~empty & ~seed_load;
  // Next state: seed_load flushes the bank; otherwise generate and consume update pointers and count
  always_comb begin
    lfsr_d    = seed_load ? ((seed == 8'h00) ? 8'h01 : seed)
              : gen ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    wr_ptr_d  = seed_load ? 3'd0 : wr_ptr_q + {2'b0, gen};
    rd_ptr_d  = seed_load ? 3'd0 : rd_ptr_q + {2'b0, cons};
    count_d   = seed_load ? 4'd0 : count_q + {3'b0, gen} - {3'b0, cons};
    written_d = seed_load ? 8'h00 : written_q | (gen ? (8'h01 << wr_ptr_q) : 8'h00);
  end
  // Control state and the registered decrypt read port; reads sample the array before this edge's write
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= 8'h01;
      wr_ptr_q  <= 3'd0;
      rd_ptr_q  <= 3'd0;
      count_q   <= 4'd0;
      written_q <= 8'h00;
      rd_ack_q  <= 1'b0;
      rd_pad_q  <= 8'h00;
      rd_hit_q  <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      written_q <= written_d;
      rd_ack_q  <= rd_req;
      if (rd_req) begin
        rd_pad_q <= mem_q[rd_idx];
        rd_hit_q <= written_q[rd_idx];
      end
    end
  end
  // Pad array has no reset; the written bitmap decides whether a slot counts as a hit
  always_ff @(posedge clk) begin
    if (!rst && gen) mem_q[wr_ptr_q] <= lfsr_q;
  end
endmodule

// File: tb/tb_otp_pad_bank.sv
// tb_otp_pad_bank: directed scenarios plus randomized traffic against a queue-based reference model
module tb_otp_pad_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b1, seed_load = 1'b0, gen_en = 1'b0, pad_ready = 1'b0, rd_req = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [2:0] rd_idx = 3'd0;
  logic       pad_valid, rd_ack, rd_hit, full, empty;
  logic [7:0] pad, rd_pad;
  logic [2:0] pad_idx;
  logic [3:0] count;
  int errors = 0, checks = 0;
  logic [7:0] m_mem [8];
  bit         m_known [8];
  bit         m_wr [8];
  int         m_q [$];
  int         m_wp = 0;
  int         m_lfsr = 1;
  bit         m_ack = 0, m_rdhit = 0, m_rdok = 1;
  logic [7:0] m_rdpad = 8'h00;

  otp_pad_bank dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .gen_en(gen_en),
    .pad_valid(pad_valid), .pad_ready(pad_ready), .pad(pad), .pad_idx(pad_idx),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_pad(rd_pad), .rd_hit(rd_hit),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_next(int l);
    return ((l * 2) % 256) + (((l >> 7) + (l >> 5) + (l >> 4) + (l >> 3)) % 2);
  endfunction

  task automatic cyc();
    if (rst) begin
      m_lfsr = 1; m_q.delete(); m_wp = 0;
      foreach (m_wr[i]) m_wr[i] = 0;
      m_ack = 0; m_rdpad = 8'h00; m_rdhit = 0; m_rdok = 1;
    end else begin
      m_ack = rd_req;
      if (rd_req) begin
        m_rdpad = m_mem[rd_idx]; m_rdhit = m_wr[rd_idx]; m_rdok = m_known[rd_idx];
      end
      if (seed_load) begin
        m_lfsr = (seed == 0) ? 1 : int'(seed);
        m_q.delete(); m_wp = 0;
        foreach (m_wr[i]) m_wr[i] = 0;
      end else begin
        bit g, c;
        g = gen_en && m_q.size() < 8;
        c = pad_ready && m_q.size() > 0;
        if (c) void'(m_q.pop_front());
        if (g) begin
          m_mem[m_wp] = 8'(m_lfsr); m_known[m_wp] = 1; m_wr[m_wp] = 1;
          m_q.push_back(m_wp);
          m_wp = (m_wp + 1) % 8;
          m_lfsr = lfsr_next(m_lfsr);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; cyc(); rst = 0;
    checks += 6;
    if (count !== 4'd0)   begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
    if (pad_valid !== 0)  begin errors++; $display("FAIL reset_valid got=%b want=0", pad_valid); end
    if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got=%b want=0", full); end
    if (rd_ack !== 1'b0 || rd_hit !== 1'b0) begin errors++; $display("FAIL reset_rd got ack=%b hit=%b want 0/0", rd_ack, rd_hit); end
    if (rd_pad !== 8'h00) begin errors++; $display("FAIL reset_rdpad got=%h want=00", rd_pad); end
  endtask

  task automatic test_fill();
    logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    rst = 1; cyc(); rst = 0;
    gen_en = 1; pad_ready = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (count !== 4'((i + 1 > 8) ? 8 : i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, (i + 1 > 8) ? 8 : i + 1); end
    end
    gen_en = 0;
    checks += 2;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b want=1", full); end
    if (pad !== 8'h01 || pad_idx !== 3'd0) begin errors++; $display("FAIL fill_head got=%h@%0d want=01@0", pad, pad_idx); end
    for (int s = 0; s < 8; s++) begin
      rd_req = 1; rd_idx = 3'(s); cyc();
      checks++;
      if (rd_pad !== exp[s] || rd_hit !== 1'b1) begin errors++; $display("FAIL fill_slot[%0d] got=%h hit=%b want=%h hit=1", s, rd_pad, rd_hit, exp[s]); end
    end
    rd_req = 0;
  endtask

  task automatic test_read();
    pad_ready = 1; cyc(); cyc(); pad_ready = 0;
    checks += 2;
    if (count !== 4'd6) begin errors++; $display("FAIL read_count got=%0d want=6", count); end
    if (pad !== 8'h04 || pad_idx !== 3'd2) begin errors++; $display("FAIL read_head got=%h@%0d want=04@2", pad, pad_idx); end
    rd_req = 1; rd_idx = 3'd1; cyc(); rd_req = 0;
    checks++;
    if (rd_ack !== 1 || rd_pad !== 8'h02 || rd_hit !== 1) begin errors++; $display("FAIL read_slot1 got ack=%b pad=%h hit=%b want 1/02/1", rd_ack, rd_pad, rd_hit); end
    cyc();
    checks++;
    if (rd_ack !== 0 || rd_pad !== 8'h02 || rd_hit !== 1) begin errors++; $display("FAIL read_hold got ack=%b pad=%h hit=%b want 0/02/1", rd_ack, rd_pad, rd_hit); end
  endtask

  task automatic test_consume_full();
    gen_en = 1; cyc(); cyc();
    checks++;
    if (full !== 1 || count !== 4'd8) begin errors++; $display("FAIL cf_full got full=%b count=%0d want 1/8", full, count); end
    pad_ready = 1; cyc(); pad_ready = 0;
    checks++;
    if (count !== 4'd7) begin errors++; $display("FAIL cf_blocked got=%0d want=7", count); end
    cyc(); gen_en = 0;
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL cf_regen got=%0d want=8", count); end
    rd_req = 1; rd_idx = 3'd2; cyc(); rd_req = 0;
    checks++;
    if (rd_pad !== 8'h71 || rd_hit !== 1) begin errors++; $display("FAIL cf_slot2 got=%h hit=%b want=71 hit=1", rd_pad, rd_hit); end
  endtask

  task automatic test_gen_consume();
    seed_load = 1; seed = 8'h5A; cyc(); seed_load = 0;
    gen_en = 1; cyc(); cyc(); cyc();
    checks++;
    if (count !== 4'd3 || pad !== 8'h5A) begin errors++; $display("FAIL gc_setup got count=%0d pad=%h want 3/5a", count, pad); end
    pad_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (pad_idx !== 3'(k)) begin errors++; $display("FAIL gc_idx[%0d] got=%0d want=%0d", k, pad_idx, k); end
      if (pad !== m_mem[m_q[0]]) begin errors++; $display("FAIL gc_pad[%0d] got=%h want=%h", k, pad, m_mem[m_q[0]]); end
      cyc();
      checks++;
      if (count !== 4'd3) begin errors++; $display("FAIL gc_count[%0d] got=%0d want=3", k, count); end
    end
    pad_ready = 0; gen_en = 0;
  endtask

  task automatic test_seed_flush();
    gen_en = 1; cyc(); cyc(); gen_en = 0;
    checks++;
    if (count !== 4'd5) begin errors++; $display("FAIL sf_setup got=%0d want=5", count); end
    seed_load = 1; seed = 8'h00; rd_req = 1; rd_idx = 3'd4; cyc(); seed_load = 0; rd_req = 0;
    checks += 2;
    if (count !== 4'd0 || empty !== 1 || pad_valid !== 0) begin errors++; $display("FAIL sf_flush got count=%0d empty=%b valid=%b want 0/1/0", count, empty, pad_valid); end
    if (rd_hit !== 1) begin errors++; $display("FAIL sf_prehit got=%b want=1", rd_hit); end
    gen_en = 1; cyc(); gen_en = 0;
    checks++;
    if (pad !== 8'h01 || pad_idx !== 3'd0 || count !== 4'd1) begin errors++; $display("FAIL sf_first got=%h@%0d count=%0d want=01@0 count=1", pad, pad_idx, count); end
    rd_req = 1; rd_idx = 3'd4; cyc(); rd_req = 0;
    checks++;
    if (rd_ack !== 1 || rd_hit !== 0) begin errors++; $display("FAIL sf_posthit got ack=%b hit=%b want 1/0", rd_ack, rd_hit); end
  endtask

  task automatic test_reset_mid();
    gen_en = 1; rd_req = 1; rd_idx = 3'd0; cyc();
    rst = 1; cyc(); rst = 0;
    checks += 2;
    if (rd_ack !== 0 || rd_pad !== 8'h00) begin errors++; $display("FAIL rm_rd got ack=%b pad=%h want 0/00", rd_ack, rd_pad); end
    if (count !== 4'd0 || empty !== 1) begin errors++; $display("FAIL rm_count got=%0d empty=%b want 0/1", count, empty); end
    cyc(); gen_en = 0; rd_req = 0;
    checks++;
    if (pad !== 8'h01 || rd_hit !== 0) begin errors++; $display("FAIL rm_after got pad=%h hit=%b want 01/0", pad, rd_hit); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 63) == 0;
      seed_load = $urandom_range(0, 31) == 0;
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      gen_en = $urandom_range(0, 3) != 0;
      pad_ready = 1'($urandom);
      rd_req = 1'($urandom);
      rd_idx = 3'($urandom);
      cyc();
      checks++;
      if (count !== 4'(m_q.size()) || empty !== (m_q.size() == 0) || full !== (m_q.size() == 8) || pad_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL rand_flags[%0d] got count=%0d want=%0d", n, count, m_q.size());
      end
      if (m_q.size() != 0) begin
        checks++;
        if (pad !== m_mem[m_q[0]] || pad_idx !== 3'(m_q[0])) begin errors++; $display("FAIL rand_pad[%0d] got=%h@%0d want=%h@%0d", n, pad, pad_idx, m_mem[m_q[0]], m_q[0]); end
      end
      checks++;
      if (rd_ack !== m_ack || rd_hit !== m_rdhit) begin errors++; $display("FAIL rand_rd[%0d] got ack=%b hit=%b want %b/%b", n, rd_ack, rd_hit, m_ack, m_rdhit); end
      if (m_rdok) begin
        checks++;
        if (rd_pad !== m_rdpad) begin errors++; $display("FAIL rand_rdpad[%0d] got=%h want=%h", n, rd_pad, m_rdpad); end
      end
    end
    rst = 0; seed_load = 0; gen_en = 0; pad_ready = 0; rd_req = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read();
    test_consume_full();
    test_gen_consume();
    test_seed_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
